// File: rtl/mem_access_if.sv
// mem_access_if: EX/MEM inputs, stall and MEM/WB outputs of the memory-access stage
interface mem_access_if;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  WB_in;
  logic [31:0] ALU_in;
  logic [31:0] RDdata2_in;
  logic [4:0]  instruction_mux_in;
  logic        stall;
  logic [1:0]  WB_out;
  logic [31:0] RDdata_out;
  logic [31:0] ALU_out;
  logic [4:0]  instruction_mux_out;
  logic        misalign;
  modport master (
    output MemWrite, MemRead, WB_in, ALU_in, RDdata2_in, instruction_mux_in,
    input  stall, WB_out, RDdata_out, ALU_out, instruction_mux_out, misalign
  );
  modport slave (
    input  MemWrite, MemRead, WB_in, ALU_in, RDdata2_in, instruction_mux_in,
    output stall, WB_out, RDdata_out, ALU_out, instruction_mux_out, misalign
  );
endinterface

// File: rtl/mem_access.sv
// mem_access: pipeline MEM stage with fixed-latency word memory; MEM_ALIGN_CHECK_EN enables misaligned-access trapping
module mem_access #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input logic         clk,
  input logic         reset,
  mem_access_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t            state;
  logic [3:0]        cnt;
  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              access, last, mis, done, load;
  assign access = bus.MemRead | bus.MemWrite;
  assign idx    = bus.ALU_in[ADDR_W+1:2];
`ifdef MEM_ALIGN_CHECK_EN
  assign mis    = access & (bus.ALU_in[1:0] != 2'b00);
`else
  assign mis    = 1'b0;
`endif
  assign last      = cnt == 4'(LATENCY - 1);
  assign done      = ~access | last | mis;
  assign load      = bus.MemRead & ~bus.MemWrite & ~mis;
  assign bus.stall = access & ~last & ~mis & ~reset;
  // store commits once, on the edge that ends the access; array is never reset
  always_ff @(posedge clk)
    if (bus.MemWrite & last & ~mis) mem[idx] <= bus.RDdata2_in;
  // latency counter FSM and MEM/WB register; bubbles WB while waiting
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state                   <= IDLE;
      cnt                     <= '0;
      bus.WB_out              <= '0;
      bus.RDdata_out          <= '0;
      bus.ALU_out             <= '0;
      bus.instruction_mux_out <= '0;
      bus.misalign            <= 1'b0;
    end else if (done) begin
      state                   <= IDLE;
      cnt                     <= '0;
      bus.WB_out              <= mis ? 2'b00 : bus.WB_in;
      bus.RDdata_out          <= load ? mem[idx] : 32'h0;
      bus.ALU_out             <= bus.ALU_in;
      bus.instruction_mux_out <= bus.instruction_mux_in;
      bus.misalign            <= bus.misalign | mis;
    end else begin
      state                   <= WAIT;
      cnt                     <= (state == IDLE) ? 4'd1 : cnt + 4'd1;
      bus.WB_out              <= 2'b00;
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table vectors, random model check and corner sequences for mem_access
module tb_mem_access;
  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;
  mem_access_if b2 ();
  mem_access_if b4 ();
  mem_access_if b1 ();
  mem_access #(.ADDR_W(8), .LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
  mem_access #(.ADDR_W(8), .LATENCY(4)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));
  mem_access #(.ADDR_W(8), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  int checks = 0;
  int failures = 0;
  logic [31:0] mm [256];
  logic        mis_m = 0;
  logic [31:0] last_alu = 0;
  typedef struct {
    string       nm;
    logic        mw, mr;
    logic [1:0]  wb;
    logic [31:0] alu, d;
    logic [4:0]  rd;
    int          st;
    logic [1:0]  ewb;
    logic [31:0] erd;
    logic        emis;
  } vec_t;
  vec_t tbl [9];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask
  // one instruction on the LATENCY=2 DUT: st stall cycles, then completion
  task automatic run(input string nm, input logic mw, input logic mr, input logic [1:0] wb,
                     input logic [31:0] alu, input logic [31:0] d, input logic [4:0] rd,
                     input int st, input logic [1:0] ewb, input logic [31:0] erd, input logic emis);
    b2.MemWrite = mw; b2.MemRead = mr; b2.WB_in = wb;
    b2.ALU_in = alu; b2.RDdata2_in = d; b2.instruction_mux_in = rd;
    for (int i = 0; i <= st; i++) begin
      #1 chk({nm, " stall"}, 32'(b2.stall), 32'(i < st));
      @(posedge clk); #1;
      if (i < st) begin
        chk({nm, " bubble_wb"}, 32'(b2.WB_out), 0);
        chk({nm, " hold_alu"}, b2.ALU_out, last_alu);
      end else begin
        chk({nm, " wb"}, 32'(b2.WB_out), 32'(ewb));
        chk({nm, " rdata"}, b2.RDdata_out, erd);
        chk({nm, " alu"}, b2.ALU_out, alu);
        chk({nm, " rd"}, 32'(b2.instruction_mux_out), 32'(rd));
        chk({nm, " misalign"}, 32'(b2.misalign), 32'(emis));
      end
      @(negedge clk);
    end
    last_alu = alu;
    b2.MemWrite = 0; b2.MemRead = 0;
  endtask
  initial begin
    logic        mw, mr, mis;
    logic [1:0]  wb, ewb;
    logic [31:0] alu, d, erd, sd;
    logic [4:0]  rd;
    int          k, op, idx;
    b2.MemWrite = 0; b2.MemRead = 0; b2.WB_in = 0; b2.ALU_in = 0; b2.RDdata2_in = 0; b2.instruction_mux_in = 0;
    b4.MemWrite = 0; b4.MemRead = 0; b4.WB_in = 0; b4.ALU_in = 0; b4.RDdata2_in = 0; b4.instruction_mux_in = 0;
    b1.MemWrite = 0; b1.MemRead = 0; b1.WB_in = 0; b1.ALU_in = 0; b1.RDdata2_in = 0; b1.instruction_mux_in = 0;
    #1 reset = 1;
    #1;
    chk("rst wb", 32'(b2.WB_out), 0);
    chk("rst rdata", b2.RDdata_out, 0);
    chk("rst alu", b2.ALU_out, 0);
    chk("rst rd", 32'(b2.instruction_mux_out), 0);
    chk("rst misalign", 32'(b2.misalign), 0);
    chk("rst stall", 32'(b2.stall), 0);
    @(negedge clk); reset = 0;
    @(negedge clk);
    tbl[0] = '{"st_dead",  1, 0, 2'b00, 32'h10,   32'hDEADBEEF, 5'd0, 1, 2'b00, 32'h0,        1'b0};
    tbl[1] = '{"ld_dead",  0, 1, 2'b11, 32'h10,   32'h0,        5'd7, 1, 2'b11, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{"alu_pass", 0, 0, 2'b10, 32'h1234, 32'h0,        5'd5, 0, 2'b10, 32'h0,        1'b0};
    tbl[3] = '{"st_wrap",  1, 0, 2'b00, 32'h400,  32'hA5A5A5A5, 5'd0, 1, 2'b00, 32'h0,        1'b0};
    tbl[4] = '{"ld_wrap",  0, 1, 2'b11, 32'h0,    32'h0,        5'd3, 1, 2'b11, 32'hA5A5A5A5, 1'b0};
    tbl[5] = '{"st_both",  1, 1, 2'b01, 32'h20,   32'h55,       5'd9, 1, 2'b01, 32'h0,        1'b0};
    tbl[6] = '{"ld_both",  0, 1, 2'b11, 32'h20,   32'h0,        5'd9, 1, 2'b11, 32'h55,       1'b0};
`ifdef MEM_ALIGN_CHECK_EN
    tbl[7] = '{"st_mis",   1, 0, 2'b01, 32'h13,   32'h77,       5'd2, 0, 2'b00, 32'h0,        1'b1};
    tbl[8] = '{"ld_mis",   0, 1, 2'b11, 32'h10,   32'h0,        5'd1, 1, 2'b11, 32'hDEADBEEF, 1'b1};
`else
    tbl[7] = '{"st_mis",   1, 0, 2'b01, 32'h13,   32'h77,       5'd2, 1, 2'b01, 32'h0,        1'b0};
    tbl[8] = '{"ld_mis",   0, 1, 2'b11, 32'h10,   32'h0,        5'd1, 1, 2'b11, 32'h77,       1'b0};
`endif
    foreach (tbl[i])
      run(tbl[i].nm, tbl[i].mw, tbl[i].mr, tbl[i].wb, tbl[i].alu, tbl[i].d, tbl[i].rd,
          tbl[i].st, tbl[i].ewb, tbl[i].erd, tbl[i].emis);
    mis_m = tbl[8].emis;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      run("preload", 1, 0, 2'b00, 32'(i * 4), d, 5'd0, 1, 2'b00, 32'h0, mis_m);
      mm[i] = d;
    end
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 3);
      mw = (op >= 2);
      mr = (op % 2 == 1);
      k = $urandom_range(0, 15);
      alu = (mw | mr) ? (($urandom & 32'hFFFFFC00) | 32'(k * 4) |
                         (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'h0))
                      : $urandom;
      d = $urandom; wb = 2'($urandom); rd = 5'($urandom);
      idx = int'((alu / 4) % 256);
`ifdef MEM_ALIGN_CHECK_EN
      mis = (mw | mr) && (alu % 4 != 0);
`else
      mis = 0;
`endif
      if (mis) begin
        ewb = 2'b00; erd = 0; mis_m = 1;
      end else begin
        ewb = wb;
        erd = (mr && !mw) ? mm[idx] : 32'h0;
        if (mw) mm[idx] = d;
      end
      run("rand", mw, mr, wb, alu, d, rd, ((mw | mr) && !mis) ? 1 : 0, ewb, erd, mis_m);
    end
    b4.MemWrite = 1; b4.ALU_in = 32'h20; b4.RDdata2_in = 32'h99;
    for (int i = 0; i < 4; i++) begin
      #1 chk("l4_st_stall", 32'(b4.stall), 32'(i < 3));
      @(posedge clk); @(negedge clk);
    end
    b4.RDdata2_in = 32'h1;
    #1 chk("l4_st2_stall", 32'(b4.stall), 1);
    @(posedge clk); @(negedge clk);
    reset = 1;
    #1;
    chk("l4_rst wb", 32'(b4.WB_out), 0);
    chk("l4_rst rdata", b4.RDdata_out, 0);
    chk("l4_rst alu", b4.ALU_out, 0);
    chk("l4_rst rd", 32'(b4.instruction_mux_out), 0);
    chk("l4_rst misalign", 32'(b4.misalign), 0);
    chk("l4_rst stall", 32'(b4.stall), 0);
    @(posedge clk); @(negedge clk);
    reset = 0;
    b4.MemWrite = 0; b4.MemRead = 1; b4.WB_in = 2'b11; b4.instruction_mux_in = 5'd6;
    for (int i = 0; i < 4; i++) begin
      #1 chk("l4_ld_stall", 32'(b4.stall), 32'(i < 3));
      @(posedge clk); #1;
      if (i < 3) chk("l4_ld_bubble", 32'(b4.WB_out), 0);
      else begin
        chk("l4_ld rdata", b4.RDdata_out, 32'h99);
        chk("l4_ld wb", 32'(b4.WB_out), 3);
        chk("l4_ld rd", 32'(b4.instruction_mux_out), 6);
      end
      @(negedge clk);
    end
    b4.MemRead = 0;
    sd = 0;
    b1.WB_in = 2'b11;
    for (int i = 0; i < 16; i++) begin
      b1.ALU_in = 32'(32'h40 + (i / 2) * 4);
      b1.MemWrite = (i % 2 == 0);
      b1.MemRead = (i % 2 == 1);
      if (i % 2 == 0) begin
        sd = $urandom;
        b1.RDdata2_in = sd;
      end
      #1 chk("l1_stall", 32'(b1.stall), 0);
      @(posedge clk); #1;
      chk("l1_rdata", b1.RDdata_out, (i % 2 == 1) ? sd : 32'h0);
      @(negedge clk);
    end
    b1.MemWrite = 0; b1.MemRead = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage pipeline. It consumes the EX/MEM register outputs (control, ALU result, store data, destination register) and performs the load or store against a word-addressed data memory whose access latency is configurable. While an access is in progress it stalls the upstream pipeline. It then registers the results into the MEM/WB boundary for writeback.

## Interface
Parameters:
- ADDR_W, 8: word-index width; the memory holds 2^ADDR_W 32-bit words.
- LATENCY, 2: cycles a load or store occupies the stage; legal range is 1 to 15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- MemWrite  in  1  store request from EX/MEM.
- MemRead  in  1  load request from EX/MEM.
- WB_in  in  2  writeback control: [1] = RegWrite, [0] = MemtoReg.
- ALU_in  in  32  byte address for loads and stores; result value otherwise.
- RDdata2_in  in  32  store data.
- instruction_mux_in  in  5  destination register number.
- stall  out  1  combinational; when high, PC, IF/ID, ID/EX and EX/MEM hold their values.
- WB_out  out  2  registered writeback control.
- RDdata_out  out  32  registered load data.
- ALU_out  out  32  registered ALU_in.
- instruction_mux_out  out  5  registered destination register.
- misalign  out  1  sticky misaligned-access flag.

## Operation
- access = MemRead | MemWrite. If both are high, the cycle is treated as a store and RDdata_out loads 0.
- Word index = ALU_in[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^ADDR_W words.
- FSM states:
  - IDLE: cnt = 0.
  - WAIT: cnt runs from 1 to LATENCY-1.
- Completing edge: the edge at which (no access) or (access and cnt == LATENCY-1).
- stall = access & (cnt != LATENCY-1).
- On a completing edge:
  - cnt goes to 0 and the FSM goes to IDLE.
  - A store writes RDdata2_in to mem[index], exactly once per store.
  - WB_out, ALU_out and instruction_mux_out load their inputs.
  - RDdata_out loads mem[index] for a load and 0 otherwise.
- On a non-completing edge:
  - cnt increments and the FSM goes to WAIT.
  - WB_out loads 2'b00 (bubble); all other outputs hold.
- EX/MEM inputs are stable throughout an access because stall freezes EX/MEM.
- Memory array has no reset; contents survive reset.

## Timing
- Reset:
  - Asynchronous; clears the FSM to IDLE and cnt to 0.
  - WB_out, RDdata_out, ALU_out, instruction_mux_out and misalign all go to 0.
  - stall goes to 0 immediately because cnt is cleared.
- Reset during WAIT: the pending store is discarded and memory is unchanged; the pending load produces no output.
- Latency, with k = LATENCY:
  - A non-memory instruction reaches the outputs 1 edge after it is presented, with no stall.
  - A load or store holds stall high for k-1 cycles and reaches the outputs on edge k.
- LATENCY = 1: stall is never asserted and the block behaves as a plain MEM/WB register.
- Back-to-back accesses: a new access begins in the cycle after a completing edge, starting from cnt = 0.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - An access with ALU_in[1:0] != 0 is misaligned.
  - A misaligned access completes on the first edge with stall low, and the store is suppressed.
  - On that edge RDdata_out loads 0, WB_out loads 2'b00, and misalign is set to 1.
  - misalign stays set until reset.
- MEM_ALIGN_CHECK_EN undefined: ALU_in[1:0] is ignored and misalign is tied to 0.

## Test plan
- Store then load, LATENCY=2:
  - Store 0xDEADBEEF to 0x10: stall is high for exactly 1 cycle and WB_out is 00 on the bubble edge.
  - Then load 0x10 with WB_in=2'b11, rd=7: RDdata_out=0xDEADBEEF, WB_out=11, instruction_mux_out=7.
- ALU pass-through: WB_in=2'b10, ALU_in=0x1234, rd=5 -> on the next edge WB_out=10, ALU_out=0x1234, RDdata_out=0; stall stays 0.
- Address wrap, ADDR_W=8: store 0xA5A5A5A5 to 0x400, then load 0x0 -> RDdata_out=0xA5A5A5A5.
- Reset mid-store, LATENCY=4:
  - Assert reset in cycle 2 of a store of 0x1 to 0x20: all outputs are 0 and stall is 0 asynchronously.
  - A subsequent load of 0x20 returns the old contents.
- Misaligned store to 0x13:
  - With MEM_ALIGN_CHECK_EN: no stall, misalign=1, WB_out=00, and a later load of 0x10 is unchanged.
  - Without the macro: the word at index 4 is written.
- LATENCY=1: alternate store and load every cycle for 16 cycles -> stall is never 1 and every load returns the preceding store's data.
